mc_control: RTL

Multi-cycle control unit for the core: a Moore/Mealy state machine that sequences each instruction over 3–5 cycles through a single shared memory port and ALU. It replaces the single-cycle combinational decoder and adds memory wait-state handling and sticky illegal-opcode detection. It sits between the instruction register (opcode/funct fields), the ALU zero flag and the datapath mux/enable controls.

---
 rtl/mc_control.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mc_control.sv
// Multi-cycle control unit: sequences each instruction over 3-5 cycles through a shared
// memory port and ALU, with memory wait states and a sticky illegal-opcode flag.
module mc_control #(
  parameter int OP_WIDTH_P        = 6,
  parameter int FUNCT_WIDTH_P     = 6,
  parameter int ALU_CNTRL_WIDTH_P = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [OP_WIDTH_P-1:0]        i_op,
  input  logic [FUNCT_WIDTH_P-1:0]     i_funct,
  input  logic                         i_zero,
  input  logic                         i_mem_ready,
  output logic                         o_pc_wr_en,
  output logic                         o_iord,
  output logic                         o_mem_rd_en,
  output logic                         o_mem_wr_en,
  output logic                         o_ir_wr_en,
  output logic                         o_reg_dst,
  output logic                         o_mem_to_reg,
  output logic                         o_reg_wr_en,
  output logic                         o_alu_src_a,
  output logic [1:0]                   o_alu_src_b,
  output logic [ALU_CNTRL_WIDTH_P-1:0] o_alu_cntrl,
  output logic [1:0]                   o_pc_src,
  output logic [3:0]                   o_state,
  output logic                         o_illegal
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [OP_WIDTH_P-1:0] OP_R    = OP_WIDTH_P'(6'b000000);
  localparam logic [OP_WIDTH_P-1:0] OP_LW   = OP_WIDTH_P'(6'b100011);
  localparam logic [OP_WIDTH_P-1:0] OP_SW   = OP_WIDTH_P'(6'b101011);
  localparam logic [OP_WIDTH_P-1:0] OP_BEQ  = OP_WIDTH_P'(6'b000100);
  localparam logic [OP_WIDTH_P-1:0] OP_BNE  = OP_WIDTH_P'(6'b000101);
  localparam logic [OP_WIDTH_P-1:0] OP_ADDI = OP_WIDTH_P'(6'b001000);
  localparam logic [OP_WIDTH_P-1:0] OP_J    = OP_WIDTH_P'(6'b000010);

  localparam logic [FUNCT_WIDTH_P-1:0] FN_ADD = FUNCT_WIDTH_P'(6'b100000);
  localparam logic [FUNCT_WIDTH_P-1:0] FN_SUB = FUNCT_WIDTH_P'(6'b100010);
  localparam logic [FUNCT_WIDTH_P-1:0] FN_AND = FUNCT_WIDTH_P'(6'b100100);
  localparam logic [FUNCT_WIDTH_P-1:0] FN_OR  = FUNCT_WIDTH_P'(6'b100101);
  localparam logic [FUNCT_WIDTH_P-1:0] FN_SLT = FUNCT_WIDTH_P'(6'b101010);

  localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_AND = ALU_CNTRL_WIDTH_P'(3'b000);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_OR  = ALU_CNTRL_WIDTH_P'(3'b001);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_ADD = ALU_CNTRL_WIDTH_P'(3'b010);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_SUB = ALU_CNTRL_WIDTH_P'(3'b110);
  localparam logic [ALU_CNTRL_WIDTH_P-1:0] ALU_SLT = ALU_CNTRL_WIDTH_P'(3'b111);

  state_t state_q, state_d;
  logic   illegal_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && state_d == S_HALT) illegal_q <= 1'b1;
    end
  end

  // NOTE: default assignment before the case keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (i_mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_HALT;
        endcase
      end
      S_MEMADR: state_d = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (i_mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (i_mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    o_pc_wr_en   = 1'b0;
    o_iord       = 1'b0;
    o_mem_rd_en  = 1'b0;
    o_mem_wr_en  = 1'b0;
    o_ir_wr_en   = 1'b0;
    o_reg_dst    = 1'b0;
    o_mem_to_reg = 1'b0;
    o_reg_wr_en  = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'b00;
    o_alu_cntrl  = ALU_AND;
    o_pc_src     = 2'b00;
    case (state_q)
      S_FETCH: begin
        o_mem_rd_en = 1'b1;
        o_alu_src_b = 2'b01;
        o_alu_cntrl = ALU_ADD;
        // Qualified by reset so a fetch completing while reset is held writes nothing.
        o_ir_wr_en  = i_mem_ready && reset;
        o_pc_wr_en  = i_mem_ready && reset;
      end
      S_DECODE: begin
        o_alu_src_b = 2'b11;
        o_alu_cntrl = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = 2'b10;
        o_alu_cntrl = ALU_ADD;
      end
      S_MEMRD: begin
        o_iord      = 1'b1;
        o_mem_rd_en = 1'b1;
      end
      S_MEMWR: begin
        o_iord      = 1'b1;
        o_mem_wr_en = 1'b1;
      end
      S_MEMWB: begin
        o_reg_wr_en  = 1'b1;
        o_mem_to_reg = 1'b1;
      end
      S_EXEC: begin
        o_alu_src_a = 1'b1;
        case (i_funct)
          FN_SUB:  o_alu_cntrl = ALU_SUB;
          FN_AND:  o_alu_cntrl = ALU_AND;
          FN_OR:   o_alu_cntrl = ALU_OR;
          FN_SLT:  o_alu_cntrl = ALU_SLT;
          FN_ADD:  o_alu_cntrl = ALU_ADD;
          default: o_alu_cntrl = ALU_ADD;
        endcase
      end
      S_ALUWB: begin
        o_reg_wr_en = 1'b1;
        o_reg_dst   = 1'b1;
      end
      S_ADDIWB: o_reg_wr_en = 1'b1;
      S_BRANCH: begin
        o_alu_src_a = 1'b1;
        o_alu_cntrl = ALU_SUB;
        o_pc_src    = 2'b01;
        o_pc_wr_en  = (i_op == OP_BNE) ? !i_zero : i_zero;
      end
      S_JUMP: begin
        o_pc_src   = 2'b10;
        o_pc_wr_en = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_state   = state_q;
  assign o_illegal = illegal_q;

endmodule
